// File: rtl/bcd_pack_tx.sv
// ASCII digit stream -> packed BCD bytes -> FIFO -> 8E1 UART transmitter.
// Two digits per byte: the first digit goes in the low nibble and the second in the high nibble.
module bcd_pack_tx #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 16,
    parameter int LINE_DIGITS = 100
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        tx,
    output logic        tx_busy,
    output logic        line_done,
    output logic        bad_char,
    output logic [15:0] bytes_sent
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(LINE_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} tx_state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic          fifo_empty, fifo_full;
    logic [7:0]    head;

    logic [3:0]    hold_reg;
    logic          hold_valid_reg;
    logic [CW-1:0] count_reg;
    logic          line_done_reg, bad_char_reg;

    tx_state_t     state_reg;
    logic [10:0]   frame_reg;
    logic [3:0]    bit_idx_reg;
    logic [15:0]   cnt_reg;
    logic          tx_reg;
    logic [15:0]   bytes_sent_reg;

    logic          transfer, is_digit, is_lf, is_cr;
    logic          push, pop;
    logic [7:0]    push_data;
    logic [3:0]    digit;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head       = mem[rd_ptr_reg[AW-1:0]];

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign char_ready = ~reset & ~fifo_full;
    assign transfer   = char_valid & char_ready;
    assign is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign is_lf      = (char_in == 8'h0A);
    assign is_cr      = (char_in == 8'h0D);
    assign digit      = char_in[3:0];
    assign pop        = (state_reg == LOAD);

    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        if (transfer && hold_valid_reg) begin
            if (is_digit) begin
                push      = 1'b1;
                push_data = {digit, hold_reg};
            end else if (is_lf) begin
                push      = 1'b1;
                push_data = {4'h0, hold_reg};
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (push)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            hold_reg       <= 4'h0;
            hold_valid_reg <= 1'b0;
            count_reg      <= '0;
            line_done_reg  <= 1'b0;
            bad_char_reg   <= 1'b0;
        end else begin
            line_done_reg <= 1'b0;
            bad_char_reg  <= 1'b0;
            if (transfer) begin
                if (is_digit) begin
                    hold_valid_reg <= ~hold_valid_reg;
                    if (!hold_valid_reg)
                        hold_reg <= digit;
                    if (count_reg == CW'(LINE_DIGITS - 1)) begin
                        count_reg     <= '0;
                        line_done_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end else if (is_lf) begin
                    hold_valid_reg <= 1'b0;
                    count_reg      <= '0;
                    line_done_reg  <= (count_reg != '0);
                end else if (!is_cr) begin
                    bad_char_reg <= 1'b1;
                end
            end
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg      <= IDLE;
            frame_reg      <= '1;
            bit_idx_reg    <= 4'd0;
            cnt_reg        <= 16'd0;
            tx_reg         <= 1'b1;
            bytes_sent_reg <= 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty)
                        state_reg <= LOAD;
                end
                LOAD: begin
                    // Frame LSB-first: start(0), data[7:0], even parity, stop(1).
                    frame_reg   <= {1'b1, ^head, head, 1'b0};
                    bit_idx_reg <= 4'd0;
                    cnt_reg     <= 16'd0;
                    tx_reg      <= 1'b0;
                    state_reg   <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_reg == 16'(CYCLES_PER_BIT - 1)) begin
                        cnt_reg <= 16'd0;
                        if (bit_idx_reg == 4'd10) begin
                            bytes_sent_reg <= bytes_sent_reg + 16'd1;
                            tx_reg         <= 1'b1;
                            state_reg      <= fifo_empty ? IDLE : LOAD;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                            tx_reg      <= frame_reg[bit_idx_reg + 4'd1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx         = tx_reg;
    assign tx_busy    = (state_reg != IDLE) | ~fifo_empty;
    assign line_done  = line_done_reg;
    assign bad_char   = bad_char_reg;
    assign bytes_sent = bytes_sent_reg;

endmodule

// File: tb/tb_bcd_pack_tx.sv
// Directed bench for bcd_pack_tx: 16 cycles/bit, 2-entry FIFO, 4-digit lines.
// A free-running line monitor decodes frames; the directed sequence checks them.
module tb_bcd_pack_tx;

    localparam int CPB = 16;
    localparam int FRAME_PERIOD = 11 * CPB + 1;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready, tx, tx_busy, line_done, bad_char;
    logic [15:0] bytes_sent;

    int total = 0;
    int passed = 0;

    logic [10:0] frames[$];
    int          starts[$];
    int          cyc = 0, ld_cnt = 0, bad_cnt = 0, ready_low = 0;
    logic        mon_active = 1'b0;
    int          mon_cnt = 0, mon_k = 0, cur_start = 0;
    logic [10:0] mon_bits = '0;

    int nf, ld0, bad0, rl0, w;

    bcd_pack_tx #(
        .CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(2), .LINE_DIGITS(4)
    ) dut (
        .sysclk(sysclk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .tx(tx), .tx_busy(tx_busy), .line_done(line_done),
        .bad_char(bad_char), .bytes_sent(bytes_sent)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    // Line monitor: samples each bit mid-period, records frame and start cycle.
    initial begin
        forever begin
            @(negedge sysclk);
            cyc++;
            if (!reset && !char_ready) ready_low++;
            if (line_done) ld_cnt++;
            if (bad_char) bad_cnt++;
            if (reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt = 0;
                    mon_bits = '0;
                    cur_start = cyc;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt >= 8 && ((mon_cnt - 8) % CPB) == 0) begin
                    mon_k = (mon_cnt - 8) / CPB;
                    mon_bits[mon_k] = tx;
                    if (mon_k == 10) begin
                        frames.push_back(mon_bits);
                        starts.push_back(cur_start);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [10:0] fr(input int i);
        if (i < frames.size()) return frames[i];
        return 11'h000;
    endfunction

    function automatic int st(input int i);
        if (i < starts.size()) return starts[i];
        return -1;
    endfunction

    task automatic send(input logic [7:0] c);
        int wt;
        @(negedge sysclk);
        char_in = c;
        char_valid = 1'b1;
        wt = 0;
        while (!char_ready && wt < 3000) begin
            @(negedge sysclk);
            wt++;
        end
        check("ready_at_send", char_ready, 1);
        @(posedge sysclk);
        #1 char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_idle();
        int wt = 0;
        @(negedge sysclk);
        while (tx_busy && wt < 5000) begin
            @(negedge sysclk);
            wt++;
        end
        check("idle_reached", tx_busy, 0);
        repeat (4) @(negedge sysclk);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        char_valid = 1'b0;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge sysclk);
        check("rst_tx", tx, 1);
        check("rst_ready", char_ready, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_line_done", line_done, 0);
        check("rst_bad_char", bad_char, 0);
        check("rst_bytes_sent", bytes_sent, 0);
        reset = 1'b0;
        $display("reset released");

        // 1: "12" -> 0x21, parity 0; start bit 2 cycles after the push
        nf = frames.size(); ld0 = ld_cnt;
        send_str("12");
        w = 0;
        @(negedge sysclk);
        while (tx !== 1'b0 && w < 100) begin
            @(negedge sysclk);
            w++;
        end
        check("t1_start_latency", w, 2);
        wait_idle();
        check("t1_nframes", frames.size() - nf, 1);
        check("t1_frame_0x21", fr(nf), 11'h442);
        check("t1_bytes_sent", bytes_sent, 1);
        check("t1_no_line_done", ld_cnt - ld0, 0);
        $display("test1 '12' frame=%03h bytes_sent=%0d", fr(nf), bytes_sent);

        // 2: "7" LF -> 0x07, parity 1, one line_done; a second LF is silent
        do_reset();
        nf = frames.size(); ld0 = ld_cnt;
        send("7");
        send(8'h0A);
        check("t2_line_done_pulse", line_done, 1);
        wait_idle();
        check("t2_nframes", frames.size() - nf, 1);
        check("t2_frame_0x07", fr(nf), 11'h60E);
        check("t2_line_done_cnt", ld_cnt - ld0, 1);
        nf = frames.size(); ld0 = ld_cnt;
        send(8'h0A);
        repeat (30) @(negedge sysclk);
        check("t2_lf_empty_nframes", frames.size() - nf, 0);
        check("t2_lf_empty_no_pulse", ld_cnt - ld0, 0);
        check("t2_lf_empty_busy", tx_busy, 0);
        $display("test2 '7'LF frame=%03h line_done=%0d", fr(nf - 1), ld_cnt);

        // 3: "9" CR "A" "8" -> 0x89, parity 1; only 'A' flagged
        do_reset();
        nf = frames.size(); bad0 = bad_cnt;
        send("9");
        send(8'h0D);
        check("t3_cr_silent", bad_char, 0);
        send("A");
        check("t3_bad_pulse", bad_char, 1);
        send("8");
        wait_idle();
        check("t3_bad_cnt", bad_cnt - bad0, 1);
        check("t3_nframes", frames.size() - nf, 1);
        check("t3_frame_0x89", fr(nf), 11'h712);
        $display("test3 '9A8' frame=%03h bad_char_pulses=%0d", fr(nf), bad_cnt - bad0);

        // 4: "1234" wraps the line; "5" held; LF flushes 0x05
        do_reset();
        nf = frames.size(); ld0 = ld_cnt;
        send_str("123");
        check("t4_no_early_line_done", ld_cnt - ld0, 0);
        send("4");
        check("t4_line_done_pulse", line_done, 1);
        wait_idle();
        check("t4_line_done_cnt", ld_cnt - ld0, 1);
        check("t4_nframes", frames.size() - nf, 2);
        check("t4_frame0_0x21", fr(nf), 11'h442);
        check("t4_frame1_0x43", fr(nf + 1), 11'h686);
        nf = frames.size(); ld0 = ld_cnt;
        send("5");
        repeat (40) @(negedge sysclk);
        check("t4_held_no_frame", frames.size() - nf, 0);
        check("t4_held_busy", tx_busy, 0);
        send(8'h0A);
        wait_idle();
        check("t4_flush_frame_0x05", fr(nf), 11'h40A);
        check("t4_flush_line_done", ld_cnt - ld0, 1);
        $display("test4 '1234' frames=%03h,%03h flush=%03h", fr(nf - 2), fr(nf - 1), fr(nf));

        // 5: back-pressure with a 2-entry FIFO
        do_reset();
        nf = frames.size(); ld0 = ld_cnt; rl0 = ready_low;
        send_str("12345678");
        wait_idle();
        check("t5_stalled", (ready_low - rl0) > 0, 1);
        check("t5_nframes", frames.size() - nf, 4);
        check("t5_frame0_0x21", fr(nf), 11'h442);
        check("t5_frame1_0x43", fr(nf + 1), 11'h686);
        check("t5_frame2_0x65", fr(nf + 2), 11'h4CA);
        check("t5_frame3_0x87", fr(nf + 3), 11'h50E);
        for (int i = 0; i < 3; i++)
            check("t5_frame_period", st(nf + i + 1) - st(nf + i), FRAME_PERIOD);
        check("t5_bytes_sent", bytes_sent, 4);
        check("t5_line_done_cnt", ld_cnt - ld0, 2);
        $display("test5 backpressure frames=%0d stall_cycles=%0d bytes_sent=%0d",
                 frames.size() - nf, ready_low - rl0, bytes_sent);

        // 6: reset in the middle of a data bit, then a clean "55"
        do_reset();
        send_str("12");
        wait_idle();
        check("t6_pre_bytes_sent", bytes_sent, 1);
        send_str("3456");
        w = 0;
        while (tx !== 1'b0 && w < 100) begin
            @(negedge sysclk);
            w++;
        end
        check("t6_frame_started", tx, 0);
        repeat (2 * CPB + 5) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        check("t6_rst_tx", tx, 1);
        check("t6_rst_busy", tx_busy, 0);
        check("t6_rst_bytes_sent", bytes_sent, 0);
        check("t6_rst_ready", char_ready, 0);
        @(negedge sysclk);
        reset = 1'b0;
        nf = frames.size();
        send_str("55");
        wait_idle();
        check("t6_nframes", frames.size() - nf, 1);
        check("t6_frame_0x55", fr(nf), 11'h4AA);
        check("t6_bytes_sent", bytes_sent, 1);
        $display("test6 mid-frame reset then '55' frame=%03h bytes_sent=%0d", fr(nf), bytes_sent);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
